bellek_islem_birimi: RTL and testbench

- Memory-access pipeline stage that sits directly upstream of veri_yolu_birimi.
- Takes one load/store micro-op from the execute stage and builds the byte mask and lane-aligned store data.
- Drives the bib_istek_* request handshake and waits for bellek_gecerli.
- Returns the extracted, sign/zero-extended load result (or store completion) to writeback, stalling execute while busy.

---
 rtl/bellek_islem_birimi_pkg.sv | 45 ++++
 rtl/bellek_veri_hizalayici.sv | 72 +++++++
 rtl/bellek_islem_birimi.sv | 180 ++++++++++++++++++
 tb/tb_bellek_islem_birimi.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bellek_islem_birimi_pkg.sv
// Shared constants for the memory-access stage: widths, micro-op codes,
// FSM state encoding and the registered request payload layout.
package bellek_islem_birimi_pkg;

  localparam int unsigned ADRES_BIT = 32;
  localparam int unsigned VERI_BIT  = 32;
  localparam int unsigned VERI_BYTE = 4;
  localparam int unsigned HEDEF_BIT = 5;
  localparam int unsigned ISLEM_BIT = 4;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Micro-op codes: bit 3 marks a store, bits [2:0] are the RISC-V funct3.
  localparam logic [ISLEM_BIT-1:0] BI_LB  = 4'b0000;
  localparam logic [ISLEM_BIT-1:0] BI_LH  = 4'b0001;
  localparam logic [ISLEM_BIT-1:0] BI_LW  = 4'b0010;
  localparam logic [ISLEM_BIT-1:0] BI_LBU = 4'b0100;
  localparam logic [ISLEM_BIT-1:0] BI_LHU = 4'b0101;
  localparam logic [ISLEM_BIT-1:0] BI_SB  = 4'b1000;
  localparam logic [ISLEM_BIT-1:0] BI_SH  = 4'b1001;
  localparam logic [ISLEM_BIT-1:0] BI_SW  = 4'b1010;
  localparam int unsigned BI_YAZ_BIT = 3;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2
  } durum_t;

  // Request fields held stable towards veri_yolu_birimi.
  typedef struct packed {
    logic [ADRES_BIT-1:0] adres;
    logic [VERI_BYTE-1:0] maske;
    logic [VERI_BIT-1:0]  veri;
  } istek_t;

  function automatic logic islem_gecerli(input logic [ISLEM_BIT-1:0] islem);
    case (islem)
      BI_LB, BI_LH, BI_LW, BI_LBU, BI_LHU, BI_SB, BI_SH, BI_SW: return HIGH;
      default: return LOW;
    endcase
  endfunction

endpackage

// File: rtl/bellek_veri_hizalayici.sv
// Combinational lane logic: store replication + byte mask and misalignment
// check for the offered op, and shift/extension of the returned load word
// for the registered op.
//   i_yurut_islem/i_yurut_ofs/i_yurut_veri : op, address[1:0], rs2 from execute
//   i_kayit_islem/i_kayit_ofs              : op and offset latched at acceptance
//   i_bellek_veri                          : aligned load word
//   o_maske_c/o_veri_c                     : byte mask and lane-aligned store data
//   o_hizasiz_c                            : offered op is misaligned
//   o_yuk_veri_c                           : extended load result
module bellek_veri_hizalayici
  import bellek_islem_birimi_pkg::*;
(
  input  logic [ISLEM_BIT-1:0] i_yurut_islem,
  input  logic [1:0]           i_yurut_ofs,
  input  logic [VERI_BIT-1:0]  i_yurut_veri,
  input  logic [ISLEM_BIT-1:0] i_kayit_islem,
  input  logic [1:0]           i_kayit_ofs,
  input  logic [VERI_BIT-1:0]  i_bellek_veri,
  output logic [VERI_BYTE-1:0] o_maske_c,
  output logic [VERI_BIT-1:0]  o_veri_c,
  output logic                 o_hizasiz_c,
  output logic [VERI_BIT-1:0]  o_yuk_veri_c
);

  logic [VERI_BIT-1:0] w_kaydirilmis;

  // Store side: replicate the source across lanes, mask selects the lanes.
  always_comb begin
    o_maske_c = '0;
    o_veri_c  = '0;
    case (i_yurut_islem)
      BI_SB: begin
        o_veri_c  = {4{i_yurut_veri[7:0]}};
        o_maske_c = 4'(4'b0001 << i_yurut_ofs);
      end
      BI_SH: begin
        o_veri_c  = {2{i_yurut_veri[15:0]}};
        o_maske_c = 4'(4'b0011 << i_yurut_ofs);
      end
      BI_SW: begin
        o_veri_c  = i_yurut_veri;
        o_maske_c = 4'b1111;
      end
      default: ;
    endcase
  end

  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    o_hizasiz_c = LOW;
    case (i_yurut_islem)
      BI_LH, BI_LHU, BI_SH: o_hizasiz_c = i_yurut_ofs[0];
      BI_LW, BI_SW:         o_hizasiz_c = |i_yurut_ofs;
      default: ;
    endcase
  end

  assign w_kaydirilmis = i_bellek_veri >> {i_kayit_ofs, 3'b000};

  always_comb begin
    o_yuk_veri_c = '0;
    case (i_kayit_islem)
      BI_LB:  o_yuk_veri_c = {{24{w_kaydirilmis[7]}}, w_kaydirilmis[7:0]};
      BI_LBU: o_yuk_veri_c = {24'd0, w_kaydirilmis[7:0]};
      BI_LH:  o_yuk_veri_c = {{16{w_kaydirilmis[15]}}, w_kaydirilmis[15:0]};
      BI_LHU: o_yuk_veri_c = {16'd0, w_kaydirilmis[15:0]};
      BI_LW:  o_yuk_veri_c = w_kaydirilmis;
      default: ;
    endcase
  end

endmodule

// File: rtl/bellek_islem_birimi.sv
// Memory-access stage: accepts one load/store micro-op, issues a single
// request to veri_yolu_birimi, waits for completion and returns the result
// to writeback. One op in flight; bib_hazir_o stalls execute while busy.
//   yurut_*          : op offer from execute (sampled only at acceptance)
//   bib_istek_*/bib_veri_o : request towards veri_yolu_birimi
//   bellek_*         : ready / load data / completion pulse from downstream
//   gy_*             : writeback completion (one-cycle pulse)
//   hizasiz_o        : misaligned-access exception pulse
module bellek_islem_birimi
  import bellek_islem_birimi_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 yurut_gecerli_i,
  input  logic [ISLEM_BIT-1:0] yurut_islem_i,
  input  logic [ADRES_BIT-1:0] yurut_adres_i,
  input  logic [VERI_BIT-1:0]  yurut_veri_i,
  input  logic [HEDEF_BIT-1:0] yurut_hedef_i,
  output logic                 bib_hazir_o,
  output logic                 bib_istek_gecerli_o,
  output logic                 bib_istek_yaz_o,
  output logic                 bib_istek_oku_o,
  output logic [ADRES_BIT-1:0] bib_istek_adres_o,
  output logic [VERI_BYTE-1:0] bib_istek_maske_o,
  output logic [VERI_BIT-1:0]  bib_veri_o,
  input  logic                 bellek_hazir_i,
  input  logic [VERI_BIT-1:0]  bellek_veri_i,
  input  logic                 bellek_gecerli_i,
  output logic                 gy_gecerli_o,
  output logic                 gy_yaz_o,
  output logic [HEDEF_BIT-1:0] gy_hedef_o,
  output logic [VERI_BIT-1:0]  gy_veri_o,
  output logic                 hizasiz_o
);

  durum_t               r_durum, w_durum;
  istek_t               r_istek, w_istek;
  logic [ISLEM_BIT-1:0] r_islem, w_islem;
  logic [1:0]           r_ofs, w_ofs;
  logic [HEDEF_BIT-1:0] r_hedef, w_hedef;
  logic                 r_hazir, w_hazir;
  logic                 r_gecerli, w_gecerli;
  logic                 r_yaz, w_yaz;
  logic                 r_oku, w_oku;
  logic                 r_hizasiz, w_hizasiz;
  logic                 r_gy_gecerli, w_gy_gecerli;
  logic                 r_gy_yaz, w_gy_yaz;
  logic [HEDEF_BIT-1:0] r_gy_hedef, w_gy_hedef;
  logic [VERI_BIT-1:0]  r_gy_veri, w_gy_veri;

  logic [VERI_BYTE-1:0] w_maske_c;
  logic [VERI_BIT-1:0]  w_veri_c;
  logic                 w_hizasiz_c;
  logic [VERI_BIT-1:0]  w_yuk_veri_c;

  bellek_veri_hizalayici u_hizalayici (
    .i_yurut_islem (yurut_islem_i),
    .i_yurut_ofs   (yurut_adres_i[1:0]),
    .i_yurut_veri  (yurut_veri_i),
    .i_kayit_islem (r_islem),
    .i_kayit_ofs   (r_ofs),
    .i_bellek_veri (bellek_veri_i),
    .o_maske_c     (w_maske_c),
    .o_veri_c      (w_veri_c),
    .o_hizasiz_c   (w_hizasiz_c),
    .o_yuk_veri_c  (w_yuk_veri_c)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_durum <= BOSTA;
    else         r_durum <= w_durum;
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_durum      = r_durum;
    w_istek      = r_istek;
    w_islem      = r_islem;
    w_ofs        = r_ofs;
    w_hedef      = r_hedef;
    w_gecerli    = r_gecerli;
    w_yaz        = r_yaz;
    w_oku        = r_oku;
    w_hizasiz    = LOW;
    w_gy_gecerli = LOW;
    w_gy_yaz     = r_gy_yaz;
    w_gy_hedef   = r_gy_hedef;
    w_gy_veri    = r_gy_veri;

    case (r_durum)
      BOSTA: begin
        if (yurut_gecerli_i) begin
          if (w_hizasiz_c) begin
            w_hizasiz = HIGH;
          end else if (islem_gecerli(yurut_islem_i)) begin
            w_istek.adres = yurut_adres_i;
            w_istek.maske = w_maske_c;
            w_istek.veri  = w_veri_c;
            w_islem       = yurut_islem_i;
            w_ofs         = yurut_adres_i[1:0];
            w_hedef       = yurut_hedef_i;
            w_gecerli     = HIGH;
            w_yaz         = yurut_islem_i[BI_YAZ_BIT];
            w_oku         = ~yurut_islem_i[BI_YAZ_BIT];
            w_durum       = ISTEK;
          end
        end
      end
      ISTEK: begin
        // Completion pulses are not expected before the handshake.
        if (bellek_hazir_i) begin
          w_gecerli = LOW;
          w_yaz     = LOW;
          w_oku     = LOW;
          w_durum   = BEKLE;
        end
      end
      BEKLE: begin
        if (bellek_gecerli_i) begin
          w_gy_gecerli = HIGH;
          w_gy_yaz     = ~r_islem[BI_YAZ_BIT];
          w_gy_hedef   = r_hedef;
          w_gy_veri    = r_islem[BI_YAZ_BIT] ? '0 : w_yuk_veri_c;
          w_durum      = BOSTA;
        end
      end
      default: w_durum = BOSTA;
    endcase

    w_hazir = (w_durum == BOSTA);
  end

  // Output and context registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_istek      <= '0;
      r_islem      <= '0;
      r_ofs        <= '0;
      r_hedef      <= '0;
      r_hazir      <= HIGH;
      r_gecerli    <= LOW;
      r_yaz        <= LOW;
      r_oku        <= LOW;
      r_hizasiz    <= LOW;
      r_gy_gecerli <= LOW;
      r_gy_yaz     <= LOW;
      r_gy_hedef   <= '0;
      r_gy_veri    <= '0;
    end else begin
      r_istek      <= w_istek;
      r_islem      <= w_islem;
      r_ofs        <= w_ofs;
      r_hedef      <= w_hedef;
      r_hazir      <= w_hazir;
      r_gecerli    <= w_gecerli;
      r_yaz        <= w_yaz;
      r_oku        <= w_oku;
      r_hizasiz    <= w_hizasiz;
      r_gy_gecerli <= w_gy_gecerli;
      r_gy_yaz     <= w_gy_yaz;
      r_gy_hedef   <= w_gy_hedef;
      r_gy_veri    <= w_gy_veri;
    end
  end

  assign bib_hazir_o         = r_hazir;
  assign bib_istek_gecerli_o = r_gecerli;
  assign bib_istek_yaz_o     = r_yaz;
  assign bib_istek_oku_o     = r_oku;
  assign bib_istek_adres_o   = r_istek.adres;
  assign bib_istek_maske_o   = r_istek.maske;
  assign bib_veri_o          = r_istek.veri;
  assign gy_gecerli_o        = r_gy_gecerli;
  assign gy_yaz_o            = r_gy_yaz;
  assign gy_hedef_o          = r_gy_hedef;
  assign gy_veri_o           = r_gy_veri;
  assign hizasiz_o           = r_hizasiz;

endmodule

// File: tb/tb_bellek_islem_birimi.sv
// Bench for bellek_islem_birimi: directed table, random ops against a
// byte-level reference model, plus stall and reset sequences.
module tb_bellek_islem_birimi;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        yurut_gecerli_i;
  logic [3:0]  yurut_islem_i;
  logic [31:0] yurut_adres_i;
  logic [31:0] yurut_veri_i;
  logic [4:0]  yurut_hedef_i;
  logic        bib_hazir_o;
  logic        bib_istek_gecerli_o;
  logic        bib_istek_yaz_o;
  logic        bib_istek_oku_o;
  logic [31:0] bib_istek_adres_o;
  logic [3:0]  bib_istek_maske_o;
  logic [31:0] bib_veri_o;
  logic        bellek_hazir_i;
  logic [31:0] bellek_veri_i;
  logic        bellek_gecerli_i;
  logic        gy_gecerli_o;
  logic        gy_yaz_o;
  logic [4:0]  gy_hedef_o;
  logic [31:0] gy_veri_o;
  logic        hizasiz_o;

  bellek_islem_birimi dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .yurut_gecerli_i     (yurut_gecerli_i),
    .yurut_islem_i       (yurut_islem_i),
    .yurut_adres_i       (yurut_adres_i),
    .yurut_veri_i        (yurut_veri_i),
    .yurut_hedef_i       (yurut_hedef_i),
    .bib_hazir_o         (bib_hazir_o),
    .bib_istek_gecerli_o (bib_istek_gecerli_o),
    .bib_istek_yaz_o     (bib_istek_yaz_o),
    .bib_istek_oku_o     (bib_istek_oku_o),
    .bib_istek_adres_o   (bib_istek_adres_o),
    .bib_istek_maske_o   (bib_istek_maske_o),
    .bib_veri_o          (bib_veri_o),
    .bellek_hazir_i      (bellek_hazir_i),
    .bellek_veri_i       (bellek_veri_i),
    .bellek_gecerli_i    (bellek_gecerli_i),
    .gy_gecerli_o        (gy_gecerli_o),
    .gy_yaz_o            (gy_yaz_o),
    .gy_hedef_o          (gy_hedef_o),
    .gy_veri_o           (gy_veri_o),
    .hizasiz_o           (hizasiz_o)
  );

  always #5 clk_i = ~clk_i;

  int hata   = 0;
  int toplam = 0;

  // tur: 0 = normal access, 1 = misaligned, 2 = unknown op (dropped)
  typedef struct {
    logic [1:0]  tur;
    logic [3:0]  maske;
    logic [31:0] veri;
    logic [31:0] gy_veri;
  } beklenen_t;

  typedef struct {
    string       ad;
    logic [3:0]  islem;
    logic [31:0] adres;
    logic [31:0] rs2;
    logic [31:0] kelime;
    logic [4:0]  hedef;
    int          hb;
    int          gb;
    beklenen_t   b;
  } vektor_t;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: got=%h expected=%h", ad, gercek, beklenen);
    end
  endtask

  task automatic kontrol1(input string ad, input logic gercek, input logic beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: got=%b expected=%b", ad, gercek, beklenen);
    end
  endtask

  // Reference: access size from funct3, byte lanes computed one by one.
  function automatic beklenen_t model(input logic [3:0] op, input logic [31:0] adres,
                                      input logic [31:0] rs2, input logic [31:0] kelime);
    beklenen_t b;
    int        boy;
    int        ofs;
    longint    deger;
    b = '{default: 0};
    ofs = int'(adres[1:0]);
    case (op)
      4'b0000, 4'b0100, 4'b1000: boy = 1;
      4'b0001, 4'b0101, 4'b1001: boy = 2;
      4'b0010, 4'b1010:          boy = 4;
      default:                   boy = 0;
    endcase
    if (boy == 0) begin
      b.tur = 2'd2;
      return b;
    end
    if ((ofs % boy) != 0) begin
      b.tur = 2'd1;
      return b;
    end
    if (op[3]) begin
      for (int i = 0; i < 4; i++) begin
        b.maske[i]     = (i >= ofs) && (i < ofs + boy);
        b.veri[8*i +: 8] = rs2[8*(i % boy) +: 8];
      end
    end else begin
      deger = 0;
      for (int k = 0; k < boy; k++)
        deger += longint'(kelime[8*(ofs+k) +: 8]) << (8*k);
      if (!op[2] && boy < 4 && deger >= (longint'(1) << (8*boy - 1)))
        deger -= longint'(1) << (8*boy);
      b.gy_veri = deger[31:0];
    end
    return b;
  endfunction

  // Offer one op and play the downstream unit: hb cycles not ready,
  // then gb wait cycles before the completion pulse.
  task automatic islem_yap(input string ad, input logic [3:0] op, input logic [31:0] adres,
                           input logic [31:0] rs2, input logic [31:0] kelime, input logic [4:0] hedef,
                           input int hb, input int gb, input beklenen_t b);
    kontrol1({ad, ".hazir_once"}, bib_hazir_o, 1'b1);
    yurut_islem_i   = op;
    yurut_adres_i   = adres;
    yurut_veri_i    = rs2;
    yurut_hedef_i   = hedef;
    yurut_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    yurut_gecerli_i = 1'b0;
    yurut_adres_i   = $urandom;
    yurut_veri_i    = $urandom;
    yurut_hedef_i   = 5'($urandom);
    kontrol1({ad, ".gy_tek_darbe"}, gy_gecerli_o, 1'b0);
    if (b.tur != 2'd0) begin
      kontrol1({ad, ".istek_yok"}, bib_istek_gecerli_o, 1'b0);
      kontrol1({ad, ".hizasiz"}, hizasiz_o, b.tur == 2'd1);
      kontrol1({ad, ".hazir_kalir"}, bib_hazir_o, 1'b1);
      @(posedge clk_i); #1;
      kontrol1({ad, ".hizasiz_bitti"}, hizasiz_o, 1'b0);
      kontrol1({ad, ".gy_yok"}, gy_gecerli_o, 1'b0);
      return;
    end
    kontrol1({ad, ".istek_gecerli"}, bib_istek_gecerli_o, 1'b1);
    kontrol1({ad, ".yaz"}, bib_istek_yaz_o, op[3]);
    kontrol1({ad, ".oku"}, bib_istek_oku_o, !op[3]);
    kontrol({ad, ".adres"}, bib_istek_adres_o, adres);
    kontrol({ad, ".maske"}, 32'(bib_istek_maske_o), 32'(b.maske));
    kontrol({ad, ".veri"}, bib_veri_o, b.veri);
    kontrol1({ad, ".mesgul"}, bib_hazir_o, 1'b0);
    for (int i = 0; i < hb; i++) begin
      bellek_hazir_i   = 1'b0;
      bellek_gecerli_i = (i == 0);
      @(posedge clk_i); #1;
      bellek_gecerli_i = 1'b0;
      kontrol1({ad, ".bekle_gecerli"}, bib_istek_gecerli_o, 1'b1);
      kontrol({ad, ".bekle_adres"}, bib_istek_adres_o, adres);
      kontrol({ad, ".bekle_maske"}, 32'(bib_istek_maske_o), 32'(b.maske));
      kontrol({ad, ".bekle_veri"}, bib_veri_o, b.veri);
      kontrol1({ad, ".bekle_gy"}, gy_gecerli_o, 1'b0);
    end
    bellek_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    kontrol1({ad, ".el_sikisma"}, bib_istek_gecerli_o, 1'b0);
    kontrol1({ad, ".el_yaz"}, bib_istek_yaz_o, 1'b0);
    kontrol1({ad, ".el_oku"}, bib_istek_oku_o, 1'b0);
    for (int i = 0; i < gb; i++) begin
      @(posedge clk_i); #1;
      kontrol1({ad, ".gy_erken"}, gy_gecerli_o, 1'b0);
    end
    bellek_veri_i    = kelime;
    bellek_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    bellek_gecerli_i = 1'b0;
    bellek_veri_i    = $urandom;
    kontrol1({ad, ".gy_gecerli"}, gy_gecerli_o, 1'b1);
    kontrol1({ad, ".gy_yaz"}, gy_yaz_o, !op[3]);
    kontrol({ad, ".gy_hedef"}, 32'(gy_hedef_o), 32'(hedef));
    kontrol({ad, ".gy_veri"}, gy_veri_o, b.gy_veri);
    kontrol1({ad, ".gy_hazir"}, bib_hazir_o, 1'b1);
  endtask

  function automatic vektor_t vek(input string ad, input logic [3:0] islem, input logic [31:0] adres,
                                  input logic [31:0] rs2, input logic [31:0] kelime, input int hb,
                                  input int gb, input logic [1:0] tur, input logic [3:0] maske,
                                  input logic [31:0] veri, input logic [31:0] gy_veri);
    vektor_t v;
    v.ad = ad; v.islem = islem; v.adres = adres; v.rs2 = rs2; v.kelime = kelime;
    v.hedef = 5'(adres[6:2] + 5'd1); v.hb = hb; v.gb = gb;
    v.b.tur = tur; v.b.maske = maske; v.b.veri = veri; v.b.gy_veri = gy_veri;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL zaman_asimi: got=timeout expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    vektor_t    tablo[$];
    beklenen_t  b;
    logic [3:0] op;
    logic [3:0] oplar[11];
    logic [31:0] a, r, k;

    rstn_i = 1'b0; yurut_gecerli_i = 1'b0; yurut_islem_i = '0; yurut_adres_i = '0;
    yurut_veri_i = '0; yurut_hedef_i = '0; bellek_hazir_i = 1'b1; bellek_veri_i = '0;
    bellek_gecerli_i = 1'b0;
    #2;
    kontrol1("rst.istek_gecerli", bib_istek_gecerli_o, 1'b0);
    kontrol("rst.adres", bib_istek_adres_o, 32'h0);
    kontrol1("rst.gy_gecerli", gy_gecerli_o, 1'b0);
    kontrol("rst.gy_veri", gy_veri_o, 32'h0);
    kontrol1("rst.hizasiz", hizasiz_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    kontrol1("rst.hazir", bib_hazir_o, 1'b1);

    tablo.push_back(vek("lw",   4'b0010, 32'h1000, 32'h0,        32'hDEADBEEF, 0, 2, 2'd0, 4'b0000, 32'h0,        32'hDEADBEEF));
    tablo.push_back(vek("lb",   4'b0000, 32'h1003, 32'h0,        32'h80FF0000, 0, 0, 2'd0, 4'b0000, 32'h0,        32'hFFFFFF80));
    tablo.push_back(vek("lbu",  4'b0100, 32'h1003, 32'h0,        32'h80FF0000, 1, 0, 2'd0, 4'b0000, 32'h0,        32'h00000080));
    tablo.push_back(vek("lh",   4'b0001, 32'h2002, 32'h0,        32'h80011234, 0, 1, 2'd0, 4'b0000, 32'h0,        32'hFFFF8001));
    tablo.push_back(vek("lhu",  4'b0101, 32'h2002, 32'h0,        32'h80011234, 0, 0, 2'd0, 4'b0000, 32'h0,        32'h00008001));
    tablo.push_back(vek("sb",   4'b1000, 32'h3001, 32'h000000AB, 32'h0,        0, 0, 2'd0, 4'b0010, 32'hABABABAB, 32'h0));
    tablo.push_back(vek("sh",   4'b1001, 32'h3002, 32'h00001234, 32'h0,        2, 0, 2'd0, 4'b1100, 32'h12341234, 32'h0));
    tablo.push_back(vek("sw",   4'b1010, 32'h4000, 32'hCAFEF00D, 32'h0,        0, 0, 2'd0, 4'b1111, 32'hCAFEF00D, 32'h0));
    tablo.push_back(vek("swmis",4'b1010, 32'h4002, 32'h11111111, 32'h0,        0, 0, 2'd1, 4'b0000, 32'h0,        32'h0));
    tablo.push_back(vek("lhmis",4'b0001, 32'h4001, 32'h0,        32'h0,        0, 0, 2'd1, 4'b0000, 32'h0,        32'h0));
    tablo.push_back(vek("bilin",4'b0011, 32'h5000, 32'h0,        32'h0,        0, 0, 2'd2, 4'b0000, 32'h0,        32'h0));
    tablo.push_back(vek("lbneg",4'b0000, 32'h1001, 32'h0,        32'h12348A00, 0, 0, 2'd0, 4'b0000, 32'h0,        32'hFFFFFF8A));

    foreach (tablo[i])
      islem_yap(tablo[i].ad, tablo[i].islem, tablo[i].adres, tablo[i].rs2, tablo[i].kelime,
                tablo[i].hedef, tablo[i].hb, tablo[i].gb, tablo[i].b);

    // Request held through a 5-cycle stall, stray completion ignored.
    b = model(4'b1001, 32'h6002, 32'h0000BEEF, 32'h0);
    islem_yap("durak", 4'b1001, 32'h6002, 32'h0000BEEF, 32'h0, 5'd9, 5, 1, b);

    // Reset in BEKLE discards the access.
    yurut_islem_i = 4'b1010; yurut_adres_i = 32'h7000; yurut_veri_i = 32'h5A5A5A5A;
    yurut_hedef_i = 5'd3; yurut_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    yurut_gecerli_i = 1'b0;
    @(posedge clk_i); #1;
    kontrol1("rstb.mesgul", bib_hazir_o, 1'b0);
    rstn_i = 1'b0;
    #1;
    kontrol1("rstb.gecerli", bib_istek_gecerli_o, 1'b0);
    kontrol1("rstb.yaz", bib_istek_yaz_o, 1'b0);
    kontrol("rstb.adres", bib_istek_adres_o, 32'h0);
    kontrol("rstb.maske", 32'(bib_istek_maske_o), 32'h0);
    kontrol("rstb.veri", bib_veri_o, 32'h0);
    kontrol1("rstb.gy_gecerli", gy_gecerli_o, 1'b0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    kontrol1("rstb.hazir", bib_hazir_o, 1'b1);
    bellek_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    bellek_gecerli_i = 1'b0;
    kontrol1("rstb.eski_tamam", gy_gecerli_o, 1'b0);

    // Random ops, including misaligned addresses and undefined codes.
    oplar = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
              4'b1010, 4'b0011, 4'b1100, 4'b0111};
    for (int n = 0; n < 60; n++) begin
      op = oplar[$urandom_range(10, 0)];
      a  = $urandom; r = $urandom; k = $urandom;
      b  = model(op, a, r, k);
      islem_yap("rastgele", op, a, r, k, 5'($urandom), int'($urandom_range(2, 0)),
                int'($urandom_range(3, 0)), b);
    end

    $display("Result: errors=%0d of %0d checks", hata, toplam);
    $finish;
  end

endmodule
